// File: rtl/fifo_mon_pkg.sv
// ---------------------------------------------------------------------------
// fifo_mon_pkg
// Shared definitions for the FIFO pointer monitor: the error vector width,
// the bit index of each error kind, the error vector type and small helper
// functions used by the monitor and its channel sub-module.
// ---------------------------------------------------------------------------
package fifo_mon_pkg;

   localparam int ERR_W        = 6;

   // Bit positions inside one channel's error vector
   localparam int ERR_FULL_MIS  = 0;
   localparam int ERR_EMPTY_MIS = 1;
   localparam int ERR_OVF       = 2;
   localparam int ERR_UNF       = 3;
   localparam int ERR_WR_GRAY   = 4;
   localparam int ERR_RD_GRAY   = 5;

   typedef logic [ERR_W-1:0] fifo_mon_err_t;

   // Binary to reflected Gray code conversion
   function automatic logic [31:0] bin2gray(input logic [31:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   // Width of a channel index, never less than one bit
   function automatic int ch_width(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

endpackage

// File: rtl/fifo_ptr_monitor_if.sv
// ---------------------------------------------------------------------------
// fifo_ptr_monitor_if
// Bundles the per-channel FIFO handshake, flag and Gray pointer signals that
// the monitor observes. Channel 0 occupies the LSBs of every vector.
//   p_write_en / p_write_full   : write request and full flag, one bit per channel
//   p_read_en  / p_read_empty   : read request and empty flag, one bit per channel
//   write_ptr_gray / read_ptr_gray : SIZE_LOG2+1 bit Gray pointer per channel
// Modports:
//   master : the FIFO side, drives all signals
//   slave  : the monitor side, observes all signals
// ---------------------------------------------------------------------------
interface fifo_ptr_monitor_if #(
   parameter int SIZE_LOG2 = 5,
   parameter int NUM_CH    = 2
);
   localparam int PW = SIZE_LOG2 + 1;

   logic [NUM_CH-1:0]    p_write_en;
   logic [NUM_CH-1:0]    p_write_full;
   logic [NUM_CH-1:0]    p_read_en;
   logic [NUM_CH-1:0]    p_read_empty;
   logic [NUM_CH*PW-1:0] write_ptr_gray;
   logic [NUM_CH*PW-1:0] read_ptr_gray;

   modport master (
      output p_write_en, p_write_full, p_read_en, p_read_empty,
      output write_ptr_gray, read_ptr_gray
   );

   modport slave (
      input p_write_en, p_write_full, p_read_en, p_read_empty,
      input write_ptr_gray, read_ptr_gray
   );

endinterface

// File: rtl/fifo_mon_channel.sv
// ---------------------------------------------------------------------------
// fifo_mon_channel
// Per-channel part of the FIFO pointer monitor. Tracks a shadow occupancy
// from accepted writes/reads, remembers the previous Gray pointers and
// accepts, and produces this cycle's error bits (masked when mon_en=0).
// Optional macro: FIFO_MON_HWM_EN adds a high-water mark register; without
// it level_hwm is tied to zero.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   mon_en                : error bits are only raised while 1
//   hwm_clr               : synchronous clear of the high-water mark
//   write_en, write_full  : write request / full flag of this channel
//   read_en, read_empty   : read request / empty flag of this channel
//   write_ptr_gray, read_ptr_gray : current Gray pointers
//   level, level_hwm      : shadow occupancy and its high-water mark
//   err                   : error bits detected in the current cycle
// ---------------------------------------------------------------------------
module fifo_mon_channel
   import fifo_mon_pkg::*;
#(
   parameter int SIZE_LOG2 = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               mon_en,
   input  logic               hwm_clr,
   input  logic               write_en,
   input  logic               write_full,
   input  logic               read_en,
   input  logic               read_empty,
   input  logic [SIZE_LOG2:0] write_ptr_gray,
   input  logic [SIZE_LOG2:0] read_ptr_gray,
   output logic [SIZE_LOG2:0] level,
   output logic [SIZE_LOG2:0] level_hwm,
   output fifo_mon_err_t      err
);

   localparam int PW = SIZE_LOG2 + 1;
   localparam logic [PW-1:0] DEPTH = {1'b1, {SIZE_LOG2{1'b0}}};

   logic          wacc;
   logic          racc;
   logic          at_full;
   logic          at_empty;
   logic          prev_wacc;
   logic          prev_racc;
   logic [PW-1:0] prev_wgray;
   logic [PW-1:0] prev_rgray;
   logic [PW-1:0] wdelta;
   logic [PW-1:0] rdelta;
   fifo_mon_err_t err_raw;

   assign wacc     = write_en & ~write_full;
   assign racc     = read_en & ~read_empty;
   assign at_full  = (level == DEPTH);
   assign at_empty = (level == '0);
   assign wdelta   = prev_wgray ^ write_ptr_gray;
   assign rdelta   = prev_rgray ^ read_ptr_gray;

   // Error detection against the registered level. A pointer must move by
   // exactly one bit after an accepted op and must stay put otherwise.
   always_comb begin
      err_raw                = '0;
      err_raw[ERR_FULL_MIS]  = write_full != at_full;
      err_raw[ERR_EMPTY_MIS] = read_empty != at_empty;
      err_raw[ERR_OVF]       = wacc & ~racc & at_full;
      err_raw[ERR_UNF]       = racc & ~wacc & at_empty;
      err_raw[ERR_WR_GRAY]   = prev_wacc ? !$onehot(wdelta) : (wdelta != '0);
      err_raw[ERR_RD_GRAY]   = prev_racc ? !$onehot(rdelta) : (rdelta != '0);
      err                    = mon_en ? err_raw : '0;
   end

   // Shadow occupancy, saturating at both ends; simultaneous accepts cancel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level <= '0;
      end else if (wacc && !racc && !at_full) begin
         level <= level + 1'b1;
      end else if (racc && !wacc && !at_empty) begin
         level <= level - 1'b1;
      end
   end

   // Previous pointers and accepts follow the bus even while checks are off,
   // so re-enabling the monitor does not flag stale pointer history.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_wgray <= '0;
         prev_rgray <= '0;
         prev_wacc  <= 1'b0;
         prev_racc  <= 1'b0;
      end else begin
         prev_wgray <= write_ptr_gray;
         prev_rgray <= read_ptr_gray;
         prev_wacc  <= wacc;
         prev_racc  <= racc;
      end
   end

`ifdef FIFO_MON_HWM_EN
   logic [PW-1:0] hwm_q;

   // High-water mark follows the registered level, so it lags a rise by one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hwm_q <= '0;
      end else if (hwm_clr) begin
         hwm_q <= '0;
      end else if (level > hwm_q) begin
         hwm_q <= level;
      end
   end

   assign level_hwm = hwm_q;
`else
   logic unused_hwm_clr;
   assign unused_hwm_clr = hwm_clr;
   assign level_hwm      = '0;
`endif

endmodule

// File: rtl/fifo_ptr_monitor.sv
// ---------------------------------------------------------------------------
// fifo_ptr_monitor
// Runtime checker for NUM_CH FIFO pointer/flag interfaces in one clock
// domain. One fifo_mon_channel per channel tracks occupancy and raises error
// bits; this level merges them into sticky bits, a saturating count of error
// cycles and a first-error record.
// Optional macro: FIFO_MON_HWM_EN enables per-channel high-water marks.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   mon_en         : 1 enables error checks; level tracking always runs
//   err_clr        : synchronous clear of sticky bits, count and first error
//   bus            : observed FIFO signals (fifo_ptr_monitor_if.slave)
//   level          : shadow occupancy per channel, ch0 in LSBs
//   level_hwm      : per-channel high-water mark (0 without the macro)
//   err_sticky     : per-channel sticky error bits, ch0 in LSBs
//   err_any        : registered OR of all sticky bits
//   err_count      : cycles with at least one new error, saturating
//   first_err_vld, first_err_ch, first_err_code : first-error record
// ---------------------------------------------------------------------------
module fifo_ptr_monitor
   import fifo_mon_pkg::*;
#(
   parameter  int SIZE_LOG2 = 5,
   parameter  int NUM_CH    = 2,
   parameter  int CNT_W     = 16,
   localparam int CH_W      = ch_width(NUM_CH),
   localparam int PW        = SIZE_LOG2 + 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    mon_en,
   input  logic                    err_clr,
   fifo_ptr_monitor_if.slave       bus,
   output logic [NUM_CH*PW-1:0]    level,
   output logic [NUM_CH*PW-1:0]    level_hwm,
   output logic [NUM_CH*ERR_W-1:0] err_sticky,
   output logic                    err_any,
   output logic [CNT_W-1:0]        err_count,
   output logic                    first_err_vld,
   output logic [CH_W-1:0]         first_err_ch,
   output fifo_mon_err_t           first_err_code
);

   fifo_mon_err_t           ch_err [NUM_CH];
   logic [NUM_CH*ERR_W-1:0] sticky_next;
   logic                    new_any;
   logic [CH_W-1:0]         first_ch_next;
   fifo_mon_err_t           first_code_next;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      fifo_mon_channel #(
         .SIZE_LOG2 (SIZE_LOG2)
      ) u_ch (
         .clk            (clk),
         .rst_n          (rst_n),
         .mon_en         (mon_en),
         .hwm_clr        (err_clr),
         .write_en       (bus.p_write_en[i]),
         .write_full     (bus.p_write_full[i]),
         .read_en        (bus.p_read_en[i]),
         .read_empty     (bus.p_read_empty[i]),
         .write_ptr_gray (bus.write_ptr_gray[i*PW +: PW]),
         .read_ptr_gray  (bus.read_ptr_gray[i*PW +: PW]),
         .level          (level[i*PW +: PW]),
         .level_hwm      (level_hwm[i*PW +: PW]),
         .err            (ch_err[i])
      );
   end

   // Merge channel errors; scanning from the top down lets the lowest
   // erroring channel win the first-error record.
   always_comb begin
      sticky_next     = err_sticky;
      new_any         = 1'b0;
      first_ch_next   = '0;
      first_code_next = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         sticky_next[i*ERR_W +: ERR_W] = err_sticky[i*ERR_W +: ERR_W] | ch_err[i];
         if (ch_err[i] != '0) begin
            new_any         = 1'b1;
            first_ch_next   = CH_W'(i);
            first_code_next = ch_err[i];
         end
      end
   end

   // Sticky bits and error counter; err_clr wins over same-cycle errors.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_sticky <= '0;
         err_count  <= '0;
         err_any    <= 1'b0;
      end else begin
         err_any <= |err_sticky;
         if (err_clr) begin
            err_sticky <= '0;
            err_count  <= '0;
         end else begin
            err_sticky <= sticky_next;
            if (new_any && (err_count != '1)) begin
               err_count <= err_count + 1'b1;
            end
         end
      end
   end

   // First-error record, frozen once valid until cleared.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         first_err_vld  <= 1'b0;
         first_err_ch   <= '0;
         first_err_code <= '0;
      end else if (err_clr) begin
         first_err_vld  <= 1'b0;
         first_err_ch   <= '0;
         first_err_code <= '0;
      end else if (!first_err_vld && new_any) begin
         first_err_vld  <= 1'b1;
         first_err_ch   <= first_ch_next;
         first_err_code <= first_code_next;
      end
   end

endmodule

// File: tb/tb_fifo_ptr_monitor.sv
// ---------------------------------------------------------------------------
// tb_fifo_ptr_monitor
// Self-checking bench for fifo_ptr_monitor with SIZE_LOG2=2, NUM_CH=2,
// CNT_W=4. A behavioural model (integer occupancy, accept counters and the
// error rules) predicts every output; directed scenarios are followed by
// randomized traffic with injected flag and pointer faults.
// Honors FIFO_MON_HWM_EN for the expected high-water mark.
// ---------------------------------------------------------------------------
module tb_fifo_ptr_monitor;

   localparam int SIZE_LOG2 = 2;
   localparam int NUM_CH    = 2;
   localparam int CNT_W     = 4;
   localparam int PW        = SIZE_LOG2 + 1;
   localparam int DEPTH     = 4;
   localparam int ERR_W     = 6;
   localparam int CH_W      = 1;
   localparam int CNT_MAX   = 15;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic                    mon_en;
   logic                    err_clr;
   logic [NUM_CH*PW-1:0]    level;
   logic [NUM_CH*PW-1:0]    level_hwm;
   logic [NUM_CH*ERR_W-1:0] err_sticky;
   logic                    err_any;
   logic [CNT_W-1:0]        err_count;
   logic                    first_err_vld;
   logic [CH_W-1:0]         first_err_ch;
   logic [ERR_W-1:0]        first_err_code;

   int errors = 0;
   int checks = 0;

   // Behavioural model state
   int       m_lvl   [NUM_CH];
   int       m_hwm   [NUM_CH];
   int       m_wcnt  [NUM_CH];
   int       m_rcnt  [NUM_CH];
   int       m_prev_w[NUM_CH];
   int       m_prev_r[NUM_CH];
   bit       m_prev_wacc[NUM_CH];
   bit       m_prev_racc[NUM_CH];
   bit [5:0] m_sticky[NUM_CH];
   bit       m_any;
   int       m_count;
   bit       m_vld;
   int       m_ch;
   bit [5:0] m_code;

   fifo_ptr_monitor_if #(.SIZE_LOG2(SIZE_LOG2), .NUM_CH(NUM_CH)) bus ();

   fifo_ptr_monitor #(
      .SIZE_LOG2 (SIZE_LOG2),
      .NUM_CH    (NUM_CH),
      .CNT_W     (CNT_W)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .mon_en         (mon_en),
      .err_clr        (err_clr),
      .bus            (bus),
      .level          (level),
      .level_hwm      (level_hwm),
      .err_sticky     (err_sticky),
      .err_any        (err_any),
      .err_count      (err_count),
      .first_err_vld  (first_err_vld),
      .first_err_ch   (first_err_ch),
      .first_err_code (first_err_code)
   );

   // Free-running monitor clock
   always #5 clk = ~clk;

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic int gray3(input int b);
      int v;
      v = b & 7;
      return v ^ (v >> 1);
   endfunction

   function automatic int ones(input int v);
      int n;
      n = 0;
      for (int i = 0; i < 8; i++) n += (v >> i) & 1;
      return n;
   endfunction

   function automatic int exp_hwm(input int ch);
`ifdef FIFO_MON_HWM_EN
      return m_hwm[ch];
`else
      return 0 * ch;
`endif
   endfunction

   task automatic model_reset();
      for (int ch = 0; ch < NUM_CH; ch++) begin
         m_lvl[ch] = 0; m_hwm[ch] = 0; m_wcnt[ch] = 0; m_rcnt[ch] = 0;
         m_prev_w[ch] = 0; m_prev_r[ch] = 0;
         m_prev_wacc[ch] = 0; m_prev_racc[ch] = 0; m_sticky[ch] = '0;
      end
      m_any = 0; m_count = 0; m_vld = 0; m_ch = 0; m_code = '0;
   endtask

   // Advance the model by one clock using the inputs currently on the bus
   task automatic model_step();
      bit [5:0] e[NUM_CH];
      bit       any_next;
      bit       new_err;
      bit       wacc, racc, found;
      int       w, r, dw, dr;
      any_next = 0;
      new_err  = 0;
      for (int ch = 0; ch < NUM_CH; ch++) any_next |= (m_sticky[ch] != 0);
      for (int ch = 0; ch < NUM_CH; ch++) begin
         wacc = bus.p_write_en[ch] && !bus.p_write_full[ch];
         racc = bus.p_read_en[ch] && !bus.p_read_empty[ch];
         w    = int'(bus.write_ptr_gray[ch*PW +: PW]);
         r    = int'(bus.read_ptr_gray[ch*PW +: PW]);
         dw   = m_prev_w[ch] ^ w;
         dr   = m_prev_r[ch] ^ r;
         e[ch] = '0;
         if (mon_en) begin
            e[ch][0] = bus.p_write_full[ch] != (m_lvl[ch] == DEPTH);
            e[ch][1] = bus.p_read_empty[ch] != (m_lvl[ch] == 0);
            e[ch][2] = wacc && !racc && (m_lvl[ch] == DEPTH);
            e[ch][3] = racc && !wacc && (m_lvl[ch] == 0);
            e[ch][4] = m_prev_wacc[ch] ? (ones(dw) != 1) : (dw != 0);
            e[ch][5] = m_prev_racc[ch] ? (ones(dr) != 1) : (dr != 0);
         end
         if (err_clr) m_hwm[ch] = 0;
         else if (m_lvl[ch] > m_hwm[ch]) m_hwm[ch] = m_lvl[ch];
         if (wacc && !racc && m_lvl[ch] < DEPTH) m_lvl[ch]++;
         else if (racc && !wacc && m_lvl[ch] > 0) m_lvl[ch]--;
         if (wacc) m_wcnt[ch]++;
         if (racc) m_rcnt[ch]++;
         m_prev_w[ch] = w;
         m_prev_r[ch] = r;
         m_prev_wacc[ch] = wacc;
         m_prev_racc[ch] = racc;
      end
      m_any = any_next;
      if (err_clr) begin
         for (int ch = 0; ch < NUM_CH; ch++) m_sticky[ch] = '0;
         m_count = 0; m_vld = 0; m_ch = 0; m_code = '0;
      end else begin
         found = 0;
         for (int ch = 0; ch < NUM_CH; ch++) begin
            m_sticky[ch] |= e[ch];
            if (e[ch] != 0) new_err = 1;
            if (!m_vld && !found && e[ch] != 0) begin
               found = 1; m_ch = ch; m_code = e[ch];
            end
         end
         if (found) m_vld = 1;
         if (new_err && m_count < CNT_MAX) m_count++;
      end
   endtask

   // Drive one channel the way a correct FIFO would, from the model's view
   task automatic drive_legal(input int ch, input bit wen, input bit ren);
      bus.p_write_en[ch]   = wen;
      bus.p_read_en[ch]    = ren;
      bus.p_write_full[ch] = (m_lvl[ch] == DEPTH);
      bus.p_read_empty[ch] = (m_lvl[ch] == 0);
      bus.write_ptr_gray[ch*PW +: PW] = PW'(gray3(m_wcnt[ch]));
      bus.read_ptr_gray[ch*PW +: PW]  = PW'(gray3(m_rcnt[ch]));
   endtask

   task automatic drive_idle();
      drive_legal(0, 0, 0);
      drive_legal(1, 0, 0);
   endtask

   // Clock the DUT and the model once; outputs are then sampled 1ns after the edge
   task automatic applyStimulus();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; mon_en = 1'b1; err_clr = 1'b0;
      model_reset();
      drive_idle();
      repeat (2) @(posedge clk);
      #1;
      checks++; if (level !== '0) begin errors++; $display("[TB] FAIL reset_level: got %h expected 0", level); end
      checks++; if (err_sticky !== '0) begin errors++; $display("[TB] FAIL reset_sticky: got %h expected 0", err_sticky); end
      checks++; if (err_count !== '0 || err_any !== 1'b0) begin errors++; $display("[TB] FAIL reset_count: got %h/%b expected 0/0", err_count, err_any); end
      checks++; if (first_err_vld !== 1'b0 || first_err_code !== '0) begin errors++; $display("[TB] FAIL reset_first: got %b/%h expected 0/0", first_err_vld, first_err_code); end
      checks++; if (level_hwm !== '0) begin errors++; $display("[TB] FAIL reset_hwm: got %h expected 0", level_hwm); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_legal_writes();
      for (int i = 0; i < 4; i++) begin
         drive_legal(0, 1, 0);
         drive_legal(1, 0, 0);
         applyStimulus();
         checks++; if (level[PW-1:0] !== PW'(m_lvl[0])) begin errors++; $display("[TB] FAIL legal_level[%0d]: got %0d expected %0d", i, level[PW-1:0], m_lvl[0]); end
         checks++; if (err_any !== 1'b0) begin errors++; $display("[TB] FAIL legal_err_any[%0d]: got %b expected 0", i, err_any); end
      end
      drive_idle();
      applyStimulus();
      checks++; if (level[PW-1:0] !== 3'd4) begin errors++; $display("[TB] FAIL legal_level_full: got %0d expected 4", level[PW-1:0]); end
      checks++; if (err_sticky !== '0) begin errors++; $display("[TB] FAIL legal_sticky: got %h expected 0", err_sticky); end
   endtask

   task automatic test_overflow();
      drive_idle();
      bus.p_write_full[0] = 1'b0;
      bus.p_write_en[0]   = 1'b1;
      applyStimulus();
      checks++; if (err_sticky[ERR_W-1:0] !== 6'b000101) begin errors++; $display("[TB] FAIL ovf_sticky0: got %b expected 000101", err_sticky[ERR_W-1:0]); end
      checks++; if (err_count !== 4'd1 || err_count !== CNT_W'(m_count)) begin errors++; $display("[TB] FAIL ovf_count: got %0d expected 1", err_count); end
      checks++; if (first_err_vld !== 1'b1 || first_err_ch !== 1'b0 || first_err_code !== 6'b000101) begin errors++; $display("[TB] FAIL ovf_first: got %b/%0d/%b expected 1/0/000101", first_err_vld, first_err_ch, first_err_code); end
      checks++; if (level[PW-1:0] !== 3'd4) begin errors++; $display("[TB] FAIL ovf_level: got %0d expected 4", level[PW-1:0]); end
      drive_idle();
      applyStimulus();
      checks++; if (err_any !== 1'b1 || err_any !== m_any) begin errors++; $display("[TB] FAIL ovf_err_any: got %b expected 1", err_any); end
      checks++; if (err_sticky[ERR_W-1:0] !== m_sticky[0]) begin errors++; $display("[TB] FAIL ovf_after_sticky: got %b expected %b", err_sticky[ERR_W-1:0], m_sticky[0]); end
   endtask

   task automatic test_gray_jump();
      drive_idle();
      bus.write_ptr_gray[PW +: PW] = 3'b011;
      applyStimulus();
      checks++; if (err_sticky[ERR_W+4] !== 1'b1 || err_sticky[ERR_W +: ERR_W] !== m_sticky[1]) begin errors++; $display("[TB] FAIL gray_jump_sticky1: got %b expected %b", err_sticky[ERR_W +: ERR_W], m_sticky[1]); end
      checks++; if (err_count !== 4'd2) begin errors++; $display("[TB] FAIL gray_jump_count: got %0d expected 2", err_count); end
      checks++; if (first_err_ch !== 1'b0 || first_err_code !== 6'b000101) begin errors++; $display("[TB] FAIL gray_jump_first: got %0d/%b expected 0/000101", first_err_ch, first_err_code); end
   endtask

   task automatic test_clr_same_cycle();
      // Pointer snaps back to 000, which is itself a jump, in the clear cycle
      drive_idle();
      err_clr = 1'b1;
      applyStimulus();
      err_clr = 1'b0;
      checks++; if (err_sticky !== '0) begin errors++; $display("[TB] FAIL clr_sticky: got %h expected 0", err_sticky); end
      checks++; if (err_count !== '0 || first_err_vld !== 1'b0) begin errors++; $display("[TB] FAIL clr_count_vld: got %0d/%b expected 0/0", err_count, first_err_vld); end
      checks++; if (level[PW-1:0] !== 3'd4 || level[PW +: PW] !== PW'(m_lvl[1])) begin errors++; $display("[TB] FAIL clr_level: got %h expected ch0=4", level); end
   endtask

   task automatic test_tie();
      drive_idle();
      bus.p_write_full[0] = 1'b0;
      bus.p_read_empty[1] = 1'b0;
      applyStimulus();
      checks++; if (first_err_vld !== 1'b1 || first_err_ch !== 1'b0) begin errors++; $display("[TB] FAIL tie_first_ch: got %b/%0d expected 1/0", first_err_vld, first_err_ch); end
      checks++; if (first_err_code !== 6'b000001 || first_err_code !== m_code) begin errors++; $display("[TB] FAIL tie_first_code: got %b expected 000001", first_err_code); end
      checks++; if (err_count !== 4'd1) begin errors++; $display("[TB] FAIL tie_count: got %0d expected 1", err_count); end
      checks++; if (err_sticky[ERR_W +: ERR_W] !== 6'b000010) begin errors++; $display("[TB] FAIL tie_sticky1: got %b expected 000010", err_sticky[ERR_W +: ERR_W]); end
      drive_idle();
      applyStimulus();
   endtask

   task automatic test_mon_en_mask();
      mon_en = 1'b0;
      drive_idle();
      bus.write_ptr_gray[PW +: PW] = 3'b011;
      applyStimulus();
      drive_idle();
      applyStimulus();
      mon_en = 1'b1;
      drive_idle();
      applyStimulus();
      checks++; if (err_sticky[ERR_W +: ERR_W] !== 6'b000010 || err_sticky !== {m_sticky[1], m_sticky[0]}) begin errors++; $display("[TB] FAIL mask_sticky: got %h expected %h", err_sticky, {m_sticky[1], m_sticky[0]}); end
      checks++; if (err_count !== 4'd1) begin errors++; $display("[TB] FAIL mask_count: got %0d expected 1", err_count); end
   endtask

   task automatic test_count_saturate();
      drive_idle();
      err_clr = 1'b1;
      applyStimulus();
      err_clr = 1'b0;
      for (int i = 0; i < 18; i++) begin
         drive_idle();
         bus.p_write_full[0] = 1'b0;
         applyStimulus();
         checks++; if (err_count !== CNT_W'(m_count)) begin errors++; $display("[TB] FAIL sat_count[%0d]: got %0d expected %0d", i, err_count, m_count); end
      end
      checks++; if (err_count !== 4'hF) begin errors++; $display("[TB] FAIL sat_count_max: got %0d expected 15", err_count); end
      drive_idle();
      applyStimulus();
   endtask

   task automatic test_hwm();
      for (int i = 0; i < 7; i++) begin
         drive_legal(0, 0, 0);
         drive_legal(1, i < 3, (i >= 3) && (i < 6));
         applyStimulus();
         checks++; if (level[PW +: PW] !== PW'(m_lvl[1])) begin errors++; $display("[TB] FAIL hwm_level[%0d]: got %0d expected %0d", i, level[PW +: PW], m_lvl[1]); end
      end
      checks++; if (level[PW +: PW] !== 3'd0) begin errors++; $display("[TB] FAIL hwm_final_level: got %0d expected 0", level[PW +: PW]); end
`ifdef FIFO_MON_HWM_EN
      checks++; if (level_hwm[PW +: PW] !== 3'd3) begin errors++; $display("[TB] FAIL hwm_value: got %0d expected 3", level_hwm[PW +: PW]); end
`else
      checks++; if (level_hwm !== '0) begin errors++; $display("[TB] FAIL hwm_tied: got %h expected 0", level_hwm); end
`endif
   endtask

   task automatic test_random();
      for (int cyc = 0; cyc < 500; cyc++) begin
         mon_en  = ($urandom_range(0, 9) != 0);
         err_clr = ($urandom_range(0, 59) == 0);
         for (int ch = 0; ch < NUM_CH; ch++) begin
            drive_legal(ch, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 11) == 0) bus.p_write_full[ch] = ~bus.p_write_full[ch];
            if ($urandom_range(0, 11) == 0) bus.p_read_empty[ch] = ~bus.p_read_empty[ch];
            if ($urandom_range(0, 19) == 0) bus.write_ptr_gray[ch*PW +: PW] ^= PW'($urandom_range(1, 7));
            if ($urandom_range(0, 19) == 0) bus.read_ptr_gray[ch*PW +: PW]  ^= PW'($urandom_range(1, 7));
         end
         applyStimulus();
         for (int ch = 0; ch < NUM_CH; ch++) begin
            checks++; if (level[ch*PW +: PW] !== PW'(m_lvl[ch])) begin errors++; $display("[TB] FAIL rnd_level ch%0d cyc%0d: got %0d expected %0d", ch, cyc, level[ch*PW +: PW], m_lvl[ch]); end
            checks++; if (level_hwm[ch*PW +: PW] !== PW'(exp_hwm(ch))) begin errors++; $display("[TB] FAIL rnd_hwm ch%0d cyc%0d: got %0d expected %0d", ch, cyc, level_hwm[ch*PW +: PW], exp_hwm(ch)); end
            checks++; if (err_sticky[ch*ERR_W +: ERR_W] !== m_sticky[ch]) begin errors++; $display("[TB] FAIL rnd_sticky ch%0d cyc%0d: got %b expected %b", ch, cyc, err_sticky[ch*ERR_W +: ERR_W], m_sticky[ch]); end
         end
         checks++; if (err_any !== m_any) begin errors++; $display("[TB] FAIL rnd_err_any cyc%0d: got %b expected %b", cyc, err_any, m_any); end
         checks++; if (err_count !== CNT_W'(m_count)) begin errors++; $display("[TB] FAIL rnd_count cyc%0d: got %0d expected %0d", cyc, err_count, m_count); end
         checks++; if (first_err_vld !== m_vld || first_err_ch !== CH_W'(m_ch) || first_err_code !== m_code) begin errors++; $display("[TB] FAIL rnd_first cyc%0d: got %b/%0d/%b expected %b/%0d/%b", cyc, first_err_vld, first_err_ch, first_err_code, m_vld, m_ch, m_code); end
      end
      mon_en  = 1'b1;
      err_clr = 1'b0;
   endtask

   task automatic test_async_reset();
      // Build up some state so the asynchronous clear is observable
      for (int i = 0; i < 2; i++) begin
         drive_legal(0, 1, 0);
         drive_legal(1, 1, 0);
         bus.p_read_empty[1] = ~bus.p_read_empty[1];
         applyStimulus();
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (level !== '0 || level_hwm !== '0) begin errors++; $display("[TB] FAIL async_rst_level: got %h/%h expected 0/0", level, level_hwm); end
      checks++; if (err_sticky !== '0 || err_any !== 1'b0 || err_count !== '0) begin errors++; $display("[TB] FAIL async_rst_err: got %h/%b/%0d expected 0/0/0", err_sticky, err_any, err_count); end
      checks++; if (first_err_vld !== 1'b0 || first_err_ch !== '0 || first_err_code !== '0) begin errors++; $display("[TB] FAIL async_rst_first: got %b/%0d/%b expected 0/0/0", first_err_vld, first_err_ch, first_err_code); end
      model_reset();
      drive_idle();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      drive_legal(0, 1, 0);
      drive_legal(1, 0, 0);
      applyStimulus();
      drive_idle();
      applyStimulus();
      checks++; if (level[PW-1:0] !== 3'd1 || err_sticky !== '0) begin errors++; $display("[TB] FAIL post_rst: got level0=%0d sticky=%h expected 1/0", level[PW-1:0], err_sticky); end
   endtask

   initial begin
      test_reset();
      test_legal_writes();
      test_overflow();
      test_gray_jump();
      test_clr_same_cycle();
      test_tie();
      test_mon_en_mask();
      test_count_saturate();
      test_hwm();
      test_random();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
